// File: rtl/sha256_multi_nonce_if.sv
// Request/response bundle for sha256_multi_nonce.
//   master: drives start, message, starter_hash, nonce_base; observes busy, done, digest
//   slave : the compression engine side
// message[k] is block word k (word 0 = first big-endian word); starter_hash[j] is Hj;
// digest[lane][j] is Hj of that lane's result.
interface sha256_multi_nonce_if #(
  parameter int unsigned LANES = 4
);
  logic                        start;
  logic [15:0][31:0]           message;
  logic [7:0][31:0]            starter_hash;
  logic [31:0]                 nonce_base;
  logic                        busy;
  logic                        done;
  logic [LANES-1:0][7:0][31:0] digest;

  modport master (
    output start, message, starter_hash, nonce_base,
    input  busy, done, digest
  );

  modport slave (
    input  start, message, starter_hash, nonce_base,
    output busy, done, digest
  );
endinterface

// File: rtl/sha256_multi_nonce.sv
// Multi-lane SHA-256 compressor. One start compresses a 512-bit block against a supplied
// chaining value in LANES lanes; lane i replaces message word NONCE_WORD with nonce_base + i.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : sha256_multi_nonce_if slave (start/message/starter_hash/nonce_base in,
//           busy/done/digest out)
// Timing: start sampled at edge 0 (IDLE), lanes loaded at edge 1, rounds 0..63 at edges
// 2..65, digest written at edge 66, done high for the cycle after edge 66.
module sha256_multi_nonce #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned NONCE_WORD = 3
) (
  input logic                 clk,
  input logic                 reset,
  sha256_multi_nonce_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StFinal, StDone} state_e;
  typedef logic [7:0][31:0]  vars_t;
  typedef logic [15:0][31:0] block_t;

  localparam logic [3:0] NonceIdx = 4'(NONCE_WORD);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // One SHA-256 round; v[0..7] = a..h.
  function automatic vars_t round_step(input vars_t v, input logic [31:0] k,
                                       input logic [31:0] w);
    logic [31:0] t1, t2;
    vars_t       r;
    t1 = v[7] + big_sigma1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = big_sigma0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    r[0] = t1 + t2;
    r[1] = v[0];
    r[2] = v[1];
    r[3] = v[2];
    r[4] = v[3] + t1;
    r[5] = v[4];
    r[6] = v[5];
    r[7] = v[6];
    return r;
  endfunction

  state_e                      state_q, state_d;
  block_t                      msg_q, msg_d;
  vars_t                       hin_q, hin_d;
  logic [31:0]                 nonce_q, nonce_d;
  logic [5:0]                  round_q, round_d;
  block_t [LANES-1:0]          w_q, w_d;   // per-lane 16-word schedule window, w[0] = W[t]
  vars_t [LANES-1:0]           wv_q, wv_d; // per-lane working vars a..h
  logic [LANES-1:0][7:0][31:0] digest_q, digest_d;

  // State transitions.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.start) state_d = StLoad;
      StLoad:    state_d = StCompute;
      StCompute: if (round_q == 6'd63) state_d = StFinal;
      StFinal:   state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    msg_d    = msg_q;
    hin_d    = hin_q;
    nonce_d  = nonce_q;
    round_d  = round_q;
    w_d      = w_q;
    wv_d     = wv_q;
    digest_d = digest_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          msg_d   = bus.message;
          hin_d   = bus.starter_hash;
          nonce_d = bus.nonce_base;
        end
      end
      StLoad: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          w_d[l]           = msg_q;
          w_d[l][NonceIdx] = nonce_q + 32'(l);  // wraps mod 2^32
          wv_d[l]          = hin_q;
        end
        round_d = 6'd0;
      end
      StCompute: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          wv_d[l] = round_step(wv_q[l], K[round_q], w_q[l][0]);
          w_d[l]  = {small_sigma1(w_q[l][14]) + w_q[l][9] + small_sigma0(w_q[l][1]) +
                     w_q[l][0], w_q[l][15:1]};
        end
        round_d = round_q + 6'd1;
      end
      StFinal: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          for (int unsigned j = 0; j < 8; j++) begin
            digest_d[l][j] = wv_q[l][j] + hin_q[j];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      digest_q <= digest_d;
    end
  end

  // Schedule, working and capture registers need no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    msg_q   <= msg_d;
    hin_q   <= hin_d;
    nonce_q <= nonce_d;
    round_q <= round_d;
    w_q     <= w_d;
    wv_q    <= wv_d;
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.digest = digest_q;

endmodule
